// File: rtl/integer_rs.sv
// Integer reservation station: holds dispatched ALU instructions, wakes pending
// operands from the CDB, and issues the lowest-index ready entry each cycle.
module integer_rs #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic        DISPATCH_VALID,
    output logic        DISPATCH_READY,
    input  logic [3:0]  DISPATCH_OPCODE,
    input  logic [4:0]  DISPATCH_SHFAMT,
    input  logic [4:0]  DISPATCH_TAG,
    input  logic [31:0] DISPATCH_OP1,
    input  logic [31:0] DISPATCH_OP2,
    input  logic        DISPATCH_OP1_VALID,
    input  logic        DISPATCH_OP2_VALID,
    input  logic [4:0]  DISPATCH_OP1_TAG,
    input  logic [4:0]  DISPATCH_OP2_TAG,
    input  logic        CDB_VALID,
    input  logic [4:0]  CDB_TAG,
    input  logic [31:0] CDB_DATA,
    output logic        ISSUE_VALID,
    input  logic        ISSUE_READY,
    output logic [3:0]  ISSUE_OPCODE,
    output logic [4:0]  ISSUE_SHFAMT,
    output logic [4:0]  ISSUE_TAG,
    output logic [31:0] ISSUE_OPERAND1,
    output logic [31:0] ISSUE_OPERAND2,
    output logic [2:0]  COUNT
);

    logic [DEPTH-1:0] busy, op1_valid, op2_valid;
    logic [3:0]       opcode  [DEPTH];
    logic [4:0]       shfamt  [DEPTH];
    logic [4:0]       tag     [DEPTH];
    logic [4:0]       op1_tag [DEPTH];
    logic [4:0]       op2_tag [DEPTH];
    logic [31:0]      op1_val [DEPTH];
    logic [31:0]      op2_val [DEPTH];

    logic [DEPTH-1:0] ready, free_onehot, sel_onehot;
    logic             any_free, any_ready;
    logic             dispatch_fire, issue_fire;
    logic             op1_bypass, op2_bypass;
    logic [2:0]       count;

    assign ready = busy & op1_valid & op2_valid;

    // Priority scan: first free slot for dispatch, first ready slot drives the issue port.
    always_comb begin
        free_onehot    = '0;
        sel_onehot     = '0;
        any_free       = 1'b0;
        any_ready      = 1'b0;
        ISSUE_OPCODE   = '0;
        ISSUE_SHFAMT   = '0;
        ISSUE_TAG      = '0;
        ISSUE_OPERAND1 = '0;
        ISSUE_OPERAND2 = '0;
        count          = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count = count + 3'(busy[i]);
            if (!busy[i] && !any_free) begin
                any_free       = 1'b1;
                free_onehot[i] = 1'b1;
            end
            if (ready[i] && !any_ready) begin
                any_ready      = 1'b1;
                sel_onehot[i]  = 1'b1;
                ISSUE_OPCODE   = opcode[i];
                ISSUE_SHFAMT   = shfamt[i];
                ISSUE_TAG      = tag[i];
                ISSUE_OPERAND1 = op1_val[i];
                ISSUE_OPERAND2 = op2_val[i];
            end
        end
    end

    assign COUNT          = count;
    assign DISPATCH_READY = any_free && !RESET;
    assign ISSUE_VALID    = any_ready && !FLUSH;
    assign dispatch_fire  = DISPATCH_VALID && DISPATCH_READY && !FLUSH;
    assign issue_fire     = ISSUE_VALID && ISSUE_READY;
    assign op1_bypass     = !DISPATCH_OP1_VALID && CDB_VALID && (DISPATCH_OP1_TAG == CDB_TAG);
    assign op2_bypass     = !DISPATCH_OP2_VALID && CDB_VALID && (DISPATCH_OP2_TAG == CDB_TAG);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy      <= '0;
            op1_valid <= '0;
            op2_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                opcode[i]  <= '0;
                shfamt[i]  <= '0;
                tag[i]     <= '0;
                op1_tag[i] <= '0;
                op2_tag[i] <= '0;
                op1_val[i] <= '0;
                op2_val[i] <= '0;
            end
        end else if (FLUSH) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (dispatch_fire && free_onehot[i]) begin
                    busy[i]      <= 1'b1;
                    opcode[i]    <= DISPATCH_OPCODE;
                    shfamt[i]    <= DISPATCH_SHFAMT;
                    tag[i]       <= DISPATCH_TAG;
                    op1_tag[i]   <= DISPATCH_OP1_TAG;
                    op2_tag[i]   <= DISPATCH_OP2_TAG;
                    op1_valid[i] <= DISPATCH_OP1_VALID || op1_bypass;
                    op2_valid[i] <= DISPATCH_OP2_VALID || op2_bypass;
                    op1_val[i]   <= op1_bypass ? CDB_DATA : DISPATCH_OP1;
                    op2_val[i]   <= op2_bypass ? CDB_DATA : DISPATCH_OP2;
                end else begin
                    if (issue_fire && sel_onehot[i])
                        busy[i] <= 1'b0;
                    if (busy[i] && !op1_valid[i] && CDB_VALID && op1_tag[i] == CDB_TAG) begin
                        op1_valid[i] <= 1'b1;
                        op1_val[i]   <= CDB_DATA;
                    end
                    if (busy[i] && !op2_valid[i] && CDB_VALID && op2_tag[i] == CDB_TAG) begin
                        op2_valid[i] <= 1'b1;
                        op2_val[i]   <= CDB_DATA;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_integer_rs.sv
// Directed bench for integer_rs: dispatch, CDB wakeup/bypass, ordering, full, flush, reset.
module tb_integer_rs;

    logic        CLK, RESET, FLUSH;
    logic        DISPATCH_VALID, DISPATCH_READY;
    logic [3:0]  DISPATCH_OPCODE;
    logic [4:0]  DISPATCH_SHFAMT, DISPATCH_TAG, DISPATCH_OP1_TAG, DISPATCH_OP2_TAG;
    logic [31:0] DISPATCH_OP1, DISPATCH_OP2;
    logic        DISPATCH_OP1_VALID, DISPATCH_OP2_VALID;
    logic        CDB_VALID;
    logic [4:0]  CDB_TAG;
    logic [31:0] CDB_DATA;
    logic        ISSUE_VALID, ISSUE_READY;
    logic [3:0]  ISSUE_OPCODE;
    logic [4:0]  ISSUE_SHFAMT, ISSUE_TAG;
    logic [31:0] ISSUE_OPERAND1, ISSUE_OPERAND2;
    logic [2:0]  COUNT;

    int total = 0;
    int bad   = 0;

    integer_rs #(.DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_READY(DISPATCH_READY),
        .DISPATCH_OPCODE(DISPATCH_OPCODE), .DISPATCH_SHFAMT(DISPATCH_SHFAMT),
        .DISPATCH_TAG(DISPATCH_TAG), .DISPATCH_OP1(DISPATCH_OP1), .DISPATCH_OP2(DISPATCH_OP2),
        .DISPATCH_OP1_VALID(DISPATCH_OP1_VALID), .DISPATCH_OP2_VALID(DISPATCH_OP2_VALID),
        .DISPATCH_OP1_TAG(DISPATCH_OP1_TAG), .DISPATCH_OP2_TAG(DISPATCH_OP2_TAG),
        .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
        .ISSUE_OPCODE(ISSUE_OPCODE), .ISSUE_SHFAMT(ISSUE_SHFAMT), .ISSUE_TAG(ISSUE_TAG),
        .ISSUE_OPERAND1(ISSUE_OPERAND1), .ISSUE_OPERAND2(ISSUE_OPERAND2),
        .COUNT(COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] opc, input logic [4:0] dtag,
                         input logic [31:0] a, input logic av, input logic [4:0] at,
                         input logic [31:0] b, input logic bv, input logic [4:0] bt);
        DISPATCH_VALID     = 1'b1;
        DISPATCH_OPCODE    = opc;
        DISPATCH_SHFAMT    = dtag;
        DISPATCH_TAG       = dtag;
        DISPATCH_OP1       = a;
        DISPATCH_OP1_VALID = av;
        DISPATCH_OP1_TAG   = at;
        DISPATCH_OP2       = b;
        DISPATCH_OP2_VALID = bv;
        DISPATCH_OP2_TAG   = bt;
    endtask

    task automatic cdb(input logic v, input logic [4:0] t, input logic [31:0] d);
        CDB_VALID = v;
        CDB_TAG   = t;
        CDB_DATA  = d;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; ISSUE_READY = 1'b0;
        DISPATCH_VALID = 1'b0;
        drive(4'h0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        DISPATCH_VALID = 1'b0;
        cdb(1'b0, 5'd0, 32'd0);

        // reset state
        #3;
        check("rst_count", 32'(COUNT), 0);
        check("rst_ivalid", 32'(ISSUE_VALID), 0);
        check("rst_dready", 32'(DISPATCH_READY), 0);
        check("rst_op1", ISSUE_OPERAND1, 0);
        tick();
        RESET = 1'b0;
        #1;
        check("rel_dready", 32'(DISPATCH_READY), 1);

        // ready dispatch
        ISSUE_READY = 1'b1;
        drive(4'h0, 5'd3, 32'd5, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0);
        tick();
        DISPATCH_VALID = 1'b0;
        check("add_valid", 32'(ISSUE_VALID), 1);
        check("add_op1", ISSUE_OPERAND1, 5);
        check("add_op2", ISSUE_OPERAND2, 7);
        check("add_tag", 32'(ISSUE_TAG), 3);
        check("add_opc", 32'(ISSUE_OPCODE), 0);
        check("add_count", 32'(COUNT), 1);
        tick();
        check("add_freed", 32'(COUNT), 0);
        check("add_idle", 32'(ISSUE_VALID), 0);

        // CDB wakeup, with a non-matching broadcast first
        drive(4'h1, 5'd5, 32'd100, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9);
        tick();
        DISPATCH_VALID = 1'b0;
        check("sub_wait0", 32'(ISSUE_VALID), 0);
        check("sub_count", 32'(COUNT), 1);
        cdb(1'b1, 5'd8, 32'h55);
        tick();
        cdb(1'b1, 5'd9, 32'h10);
        check("sub_wait1", 32'(ISSUE_VALID), 0);
        tick();
        cdb(1'b0, 5'd0, 32'd0);
        check("sub_valid", 32'(ISSUE_VALID), 1);
        check("sub_op2", ISSUE_OPERAND2, 32'h10);
        check("sub_op1", ISSUE_OPERAND1, 100);
        check("sub_tag", 32'(ISSUE_TAG), 5);
        check("sub_opc", 32'(ISSUE_OPCODE), 1);
        tick();
        check("sub_freed", 32'(COUNT), 0);

        // dispatch/CDB bypass
        drive(4'h2, 5'd6, 32'd0, 1'b0, 5'd4, 32'd3, 1'b1, 5'd0);
        cdb(1'b1, 5'd4, 32'hDEAD);
        tick();
        DISPATCH_VALID = 1'b0;
        cdb(1'b0, 5'd0, 32'd0);
        check("byp_valid", 32'(ISSUE_VALID), 1);
        check("byp_op1", ISSUE_OPERAND1, 32'hDEAD);
        check("byp_tag", 32'(ISSUE_TAG), 6);
        tick();
        check("byp_freed", 32'(COUNT), 0);

        // full and backpressure
        ISSUE_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'h3, 5'(10 + i), 32'(i + 1), 1'b1, 5'd0, 32'(256 + i), 1'b1, 5'd0);
            tick();
        end
        check("full_count", 32'(COUNT), 4);
        check("full_dready", 32'(DISPATCH_READY), 0);
        drive(4'h3, 5'd14, 32'd99, 1'b1, 5'd0, 32'd99, 1'b1, 5'd0);
        tick();
        DISPATCH_VALID = 1'b0;
        check("full_drop", 32'(COUNT), 4);
        check("full_hold", 32'(ISSUE_TAG), 10);
        ISSUE_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("order_valid", 32'(ISSUE_VALID), 1);
            check("order_tag", 32'(ISSUE_TAG), 32'(10 + k));
            check("order_op1", ISSUE_OPERAND1, 32'(k + 1));
            tick();
            if (k == 0) check("refill_dready", 32'(DISPATCH_READY), 1);
        end
        check("drain_count", 32'(COUNT), 0);
        check("drain_ivalid", 32'(ISSUE_VALID), 0);

        // simultaneous dispatch and issue
        ISSUE_READY = 1'b0;
        drive(4'h4, 5'd20, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0);
        tick();
        ISSUE_READY = 1'b1;
        drive(4'h5, 5'd21, 32'd3, 1'b1, 5'd0, 32'd4, 1'b1, 5'd0);
        tick();
        DISPATCH_VALID = 1'b0;
        check("both_count", 32'(COUNT), 1);
        check("both_tag", 32'(ISSUE_TAG), 21);
        tick();
        check("both_freed", 32'(COUNT), 0);

        // lower-index entry becoming ready takes over the issue port
        ISSUE_READY = 1'b0;
        drive(4'h6, 5'd22, 32'd0, 1'b0, 5'd7, 32'd1, 1'b1, 5'd0);
        tick();
        drive(4'h7, 5'd23, 32'd8, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0);
        tick();
        DISPATCH_VALID = 1'b0;
        check("pre_tag", 32'(ISSUE_TAG), 23);
        cdb(1'b1, 5'd7, 32'h77);
        tick();
        cdb(1'b0, 5'd0, 32'd0);
        check("pre_switch", 32'(ISSUE_TAG), 22);
        check("pre_op1", ISSUE_OPERAND1, 32'h77);
        ISSUE_READY = 1'b1;
        tick();
        check("pre_next", 32'(ISSUE_TAG), 23);
        tick();
        check("pre_freed", 32'(COUNT), 0);

        // flush with a dispatch in the same cycle
        ISSUE_READY = 1'b0;
        drive(4'h8, 5'd24, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        tick();
        drive(4'h9, 5'd25, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        tick();
        check("fl_count0", 32'(COUNT), 2);
        drive(4'hA, 5'd26, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        FLUSH = 1'b1;
        ISSUE_READY = 1'b1;
        #1;
        check("fl_noissue", 32'(ISSUE_VALID), 0);
        tick();
        FLUSH = 1'b0;
        DISPATCH_VALID = 1'b0;
        check("fl_count", 32'(COUNT), 0);
        check("fl_ivalid", 32'(ISSUE_VALID), 0);
        check("fl_dready", 32'(DISPATCH_READY), 1);

        // asynchronous reset mid-operation
        ISSUE_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'hB, 5'(27 + i), 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
            tick();
        end
        DISPATCH_VALID = 1'b0;
        check("mr_count0", 32'(COUNT), 3);
        #2;
        RESET = 1'b1;
        #1;
        check("mr_count", 32'(COUNT), 0);
        check("mr_ivalid", 32'(ISSUE_VALID), 0);
        check("mr_dready", 32'(DISPATCH_READY), 0);
        tick();
        RESET = 1'b0;
        #1;
        check("mr_release", 32'(DISPATCH_READY), 1);
        check("mr_count1", 32'(COUNT), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/integer_rs.md
# integer_rs

Integer reservation station feeding the Integer ALU in the Tomasulo datapath. It accepts dispatched integer instructions with operands that are either ready values or pending producer tags, and snoops the common data bus (CDB) to capture pending operands. It issues one ready instruction per cycle to the ALU as opcode, operands, shift amount and destination tag. The ALU reflects that tag back to the CDB.

## Interface
- DEPTH, 4, number of entries (1..7)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high; clears all entries
- FLUSH  in  1  synchronous clear of all entries (branch mispredict)
- DISPATCH_VALID  in  1  dispatch request
- DISPATCH_READY  out  1  at least one free entry
- DISPATCH_OPCODE  in  4  ALU opcode (0x0 ADD … 0xB BNE)
- DISPATCH_SHFAMT  in  5  shift amount
- DISPATCH_TAG  in  5  destination tag of this instruction
- DISPATCH_OP1 / DISPATCH_OP2  in  32  operand value, meaningful when matching _VALID=1
- DISPATCH_OP1_VALID / DISPATCH_OP2_VALID  in  1  operand value is final
- DISPATCH_OP1_TAG / DISPATCH_OP2_TAG  in  5  producer tag when _VALID=0
- CDB_VALID  in  1  broadcast valid
- CDB_TAG  in  5  broadcasting producer tag
- CDB_DATA  in  32  broadcast result
- ISSUE_VALID  out  1  issue outputs hold a ready instruction
- ISSUE_READY  in  1  ALU stage accepts this cycle
- ISSUE_OPCODE  out  4; ISSUE_SHFAMT  out  5; ISSUE_TAG  out  5
- ISSUE_OPERAND1 / ISSUE_OPERAND2  out  32
- COUNT  out  3  occupied entries

## Operation
- Entry state: busy, opcode, shfamt, tag, and per operand {valid, tag, value}.
- Dispatch fires when DISPATCH_VALID && DISPATCH_READY && !FLUSH. It writes the lowest-index free entry.
- DISPATCH_READY is 1 when at least one entry is free, based on state at start of cycle. An entry freed by issue in the same cycle does not count. It is 0 while RESET is high.
- CDB snoop: each busy entry with operand valid=0 and operand tag == CDB_TAG while CDB_VALID captures CDB_DATA and sets valid=1.
- Dispatch/CDB bypass: a dispatched operand with _VALID=0 whose _TAG equals CDB_TAG while CDB_VALID is written as valid with CDB_DATA.
- Ready entry: busy && op1 valid && op2 valid.
- Select: lowest-index ready entry. ISSUE_* is driven combinationally from that entry. ISSUE_VALID=1 when any ready entry exists and FLUSH=0.
- Issue handshake: ISSUE_VALID && ISSUE_READY frees the selected entry at the edge.
- Without ISSUE_READY, the same entry stays selected unless a lower-index entry becomes ready. The outputs then switch to that entry, and nothing is lost.
- A simultaneous dispatch and issue in one cycle is legal. COUNT is unchanged in that case.
- FLUSH: at the edge, all busy bits clear. The dispatch in that cycle is dropped, and no issue completes.
- BEQ/BNE entries are treated like any other opcode. The branch result is the ALU's responsibility.

## Timing
- Reset values: all busy=0, ISSUE_VALID=0, COUNT=0, ISSUE_* data=0. DISPATCH_READY=0 during reset and 1 from the first cycle after release.
- Dispatch with both operands valid, accepted at edge k: ISSUE_VALID=1 in cycle k→k+1.
- Pending operand satisfied by CDB at edge k: the entry becomes ready and is issuable in the cycle after edge k.
- Throughput: one dispatch and one issue per cycle.
- Full (COUNT=DEPTH): DISPATCH_READY=0. It returns to 1 the cycle after an issue handshake.
- Empty: ISSUE_VALID=0, ISSUE_* data don't-care.

## Test plan
- Reset mid-operation: fill 3 entries, assert RESET asynchronously → COUNT=0, ISSUE_VALID=0 immediately, DISPATCH_READY=1 after release.
- Ready dispatch: ADD, op1=5, op2=7, tag=3, ISSUE_READY=1 → next cycle ISSUE_VALID=1 with operands 5/7, tag 3, opcode 0x0. Entry freed after one cycle.
- CDB wakeup: dispatch SUB with op2 pending on tag 9; CDB tag 9 data 0x10 two cycles later → issue the following cycle with ISSUE_OPERAND2=0x10. Never issued before the CDB broadcast.
- Bypass: dispatch with op1 pending on tag 4 while CDB_VALID, tag 4, data 0xDEAD in the same cycle → entry issues next cycle with operand1=0xDEAD.
- Full/backpressure: ISSUE_READY=0, dispatch 4 ready ops → COUNT=4, DISPATCH_READY=0, fifth dispatch ignored. Release ISSUE_READY → issue order entry 0,1,2,3, one per cycle.
- Flush: 2 busy entries plus a dispatch in the FLUSH cycle → next cycle COUNT=0, ISSUE_VALID=0, no handshake in the FLUSH cycle.
